// File: rtl/ptp_bridge_sc_fifo_inff_core_pkg.sv
// Shared pipeline depths for the PTP bridge single-clock FIFO.
// Contents: stage counts for the optional input register, the write-to-visible
// delay and the error-pulse delay.
package ptp_bridge_sc_fifo_inff_core_pkg;

    // Register stages between wrreq/din and the storage write port
    localparam int unsigned INFF_DEPTH = 1;
    // Clocks from an accepted write (wr_i) to fifo_push
    localparam int unsigned PUSH_DEPTH = 2;
    // Clocks from an offending cycle to its overflow/underflow pulse
    localparam int unsigned ERR_DEPTH  = 2;

endpackage

// File: rtl/ptp_bridge_sc_pipe_stage.sv
// N-deep register delay line, every stage cleared by reset.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   d_i    W-bit input
//   q_o    d_i delayed by N clocks
module ptp_bridge_sc_pipe_stage #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    for (genvar g = 0; g < N; g++) begin : g_stage
        logic [W-1:0] stage_q;
        logic [W-1:0] stage_d;

        if (g == 0) begin : g_head
            assign stage_d = d_i;
        end else begin : g_tail
            assign stage_d = g_stage[g-1].stage_q;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign q_o = g_stage[N-1].stage_q;

endmodule

// File: rtl/ptp_bridge_sc_fifo_inff_core.sv
// Single-clock show-ahead FIFO for PTP bridge sideband/timestamp words, with an
// optional input register, look-ahead empty flag and overflow/underflow pulses.
// Ports:
//   clk1           clock (rising edge)
//   rst            asynchronous active-high reset
//   din/wrreq      write data / write request
//   rdreq          acknowledge of the head word
//   dout           head word, valid while rdempty=0
//   rdempty        no readable word
//   wrfull         NUM_WORDS words stored
//   wrusedw        occupancy modulo NUM_WORDS
//   rdempty_lkahd  predicted empty for the next cycle (combinational)
//   overflow       pulse two clocks after a write while full
//   underflow      pulse two clocks after a read while empty
module ptp_bridge_sc_fifo_inff_core
    import ptp_bridge_sc_fifo_inff_core_pkg::*;
#(
    parameter int unsigned DWD            = 2,
    parameter int unsigned NUM_WORDS      = 8,
    parameter int unsigned NO_INFF        = 0,
    parameter string       RAM_BLOCK_TYPE = "AUTO",
    localparam int unsigned AW            = $clog2(NUM_WORDS)
) (
    input  logic           clk1,
    input  logic           rst,
    input  logic [DWD-1:0] din,
    input  logic           wrreq,
    input  logic           rdreq,
    output logic [DWD-1:0] dout,
    output logic           rdempty,
    output logic           wrfull,
    output logic [AW-1:0]  wrusedw,
    output logic           rdempty_lkahd,
    output logic           overflow,
    output logic           underflow
);

    localparam int unsigned CW = AW + 1;

    // Elaboration guard on parameters
    if (NUM_WORDS < 4 || (NUM_WORDS & (NUM_WORDS - 1)) != 0 || RAM_BLOCK_TYPE == "") begin : g_bad_param
        $error("NUM_WORDS must be a power of two >= 4 and RAM_BLOCK_TYPE non-empty");
    end

    logic           wr_i;
    logic [DWD-1:0] din_i;
    logic           wr_acc;
    logic           rd_acc;
    logic           fifo_push;

    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  used_q, used_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DWD-1:0] dout_q, dout_d;

    (* ramstyle = RAM_BLOCK_TYPE *) logic [DWD-1:0] mem_q [NUM_WORDS];

    // Optional input register on {din, wrreq}
    if (NO_INFF == 0) begin : g_inff
        logic [DWD:0] inff_out;
        ptp_bridge_sc_pipe_stage #(.W(DWD + 1), .N(INFF_DEPTH)) u_inff (
            .clk_i (clk1),
            .rst_i (rst),
            .d_i   ({din, wrreq}),
            .q_o   (inff_out)
        );
        assign din_i = inff_out[DWD:1];
        assign wr_i  = inff_out[0];
    end else begin : g_no_inff
        assign din_i = din;
        assign wr_i  = wrreq;
    end

    assign wrfull  = (used_q == CW'(NUM_WORDS));
    assign wrusedw = used_q[AW-1:0];
    assign rdempty = (cnt_q == '0);
    assign dout    = dout_q;

    assign wr_acc = wr_i & ~wrfull;
    assign rd_acc = rdreq & ~rdempty;

    // Only accepted writes travel to the visible count, so dropped words never surface
    ptp_bridge_sc_pipe_stage #(.W(1), .N(PUSH_DEPTH)) u_push (
        .clk_i (clk1),
        .rst_i (rst),
        .d_i   (wr_acc),
        .q_o   (fifo_push)
    );

    // Error pulses: raw offending conditions delayed two clocks
    ptp_bridge_sc_pipe_stage #(.W(2), .N(ERR_DEPTH)) u_err (
        .clk_i (clk1),
        .rst_i (rst),
        .d_i   ({wrfull & wr_i, rdempty & rdreq}),
        .q_o   ({overflow, underflow})
    );

    assign rdempty_lkahd = (~fifo_push & rdreq & (cnt_q == CW'(1))) | rdempty;

    // Storage write port
    always_ff @(posedge clk1) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // Pointer, occupancy, visible count and head-word next state
    always_comb begin
        wptr_d = wptr_q + AW'(wr_acc);
        rptr_d = rptr_q + AW'(rd_acc);
        used_d = used_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;

        if (wr_acc && !rd_acc) begin
            used_d = used_q + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            used_d = used_q - CW'(1);
        end

        if (fifo_push && !rd_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!fifo_push && rd_acc) begin
            cnt_d = cnt_q - CW'(1);
        end

        // The word at rptr_d was written at least two clocks ago whenever cnt_d is non-zero
        if (cnt_d != '0) begin
            dout_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            used_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            used_q <= used_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: tb/tb_ptp_bridge_sc_fifo_inff_core.sv
// Self-checking bench for ptp_bridge_sc_fifo_inff_core (DWD=4, NUM_WORDS=8, NO_INFF=0).
module tb_ptp_bridge_sc_fifo_inff_core;

    localparam int unsigned DWD       = 4;
    localparam int unsigned NUM_WORDS = 8;
    localparam int unsigned AW        = 3;

    logic           clk1;
    logic           rst;
    logic [DWD-1:0] din;
    logic           wrreq;
    logic           rdreq;
    logic [DWD-1:0] dout;
    logic           rdempty;
    logic           wrfull;
    logic [AW-1:0]  wrusedw;
    logic           rdempty_lkahd;
    logic           overflow;
    logic           underflow;

    typedef struct packed {
        logic           wr;
        logic [DWD-1:0] d;
        logic           rd;
        logic [AW-1:0]  usedw;
        logic           full;
        logic           empty;
        logic           ovf;
    } vec_t;

    vec_t           tbl [13];
    logic [DWD-1:0] sb [$];
    int             n_chk;
    int             n_pass;
    int             n_pop;

    ptp_bridge_sc_fifo_inff_core #(
        .DWD            (DWD),
        .NUM_WORDS      (NUM_WORDS),
        .NO_INFF        (0),
        .RAM_BLOCK_TYPE ("AUTO")
    ) dut (
        .clk1          (clk1),
        .rst           (rst),
        .din           (din),
        .wrreq         (wrreq),
        .rdreq         (rdreq),
        .dout          (dout),
        .rdempty       (rdempty),
        .wrfull        (wrfull),
        .wrusedw       (wrusedw),
        .rdempty_lkahd (rdempty_lkahd),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    // Drive one cycle of inputs; scoreboard pushes accepted writes and checks popped heads
    task automatic drive(input logic wr, input logic [DWD-1:0] d, input logic rd);
        logic [DWD-1:0] exp;
        wrreq = wr;
        din   = d;
        rdreq = rd;
        #1;
        if (wr && sb.size() < NUM_WORDS) sb.push_back(d);
        if (rd && !rdempty) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_underrun: DUT offered 0x%0h, want no word", dout);
            end else begin
                exp = sb.pop_front();
                check("sb_dout", dout, exp);
                n_pop++;
            end
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [DWD-1:0] d, input logic [AW-1:0] u,
                                input logic f, input logic e, input logic o);
        vec_t v;
        v.wr = wr; v.d = d; v.rd = 1'b0; v.usedw = u; v.full = f; v.empty = e; v.ovf = o;
        return v;
    endfunction

    initial begin
        int n;
        int pos;
        int hits;
        logic exp_lk;

        n_chk = 0; n_pass = 0; n_pop = 0;

        // Fill burst of 9 writes: expected outputs sampled in each cycle
        for (int i = 0; i < 9; i++) begin
            tbl[i] = mk(1'b1, DWD'(i), (i < 2) ? '0 : AW'(i - 1), 1'b0, (i < 4), 1'b0);
        end
        tbl[9]  = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; din = '0;
        repeat (2) @(posedge clk1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_rdempty", rdempty, 1);
        check("rst_wrfull", wrfull, 0);
        check("rst_wrusedw", wrusedw, 0);
        check("rst_dout", dout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_lkahd", rdempty_lkahd, 1);

        // Single write latency
        drive(1'b1, 4'h2, 1'b0);
        check("single_empty_at_req", rdempty, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        n = 0;
        while (rdempty && n < 10) begin
            tick();
            n++;
        end
        check("single_latency", n, 3);
        check("single_dout", dout, 4'h2);
        check("single_wrusedw", wrusedw, 1);
        drive(1'b0, '0, 1'b1);
        check("single_lkahd", rdempty_lkahd, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        check("single_empty_after", rdempty, 1);
        check("single_dout_hold", dout, 4'h2);
        check("single_wrusedw_after", wrusedw, 0);

        // Table: fill to full, dropped 9th write, single overflow pulse
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wr, tbl[i].d, tbl[i].rd);
            check($sformatf("vec%0d_wrusedw", i), wrusedw, tbl[i].usedw);
            check($sformatf("vec%0d_wrfull", i), wrfull, tbl[i].full);
            check($sformatf("vec%0d_rdempty", i), rdempty, tbl[i].empty);
            check($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
            tick();
        end

        // Drain: order 0..7, look-ahead empty on the last read
        n_pop = 0;
        for (int k = 0; k < 12 && !rdempty; k++) begin
            exp_lk = (sb.size() == 1);
            drive(1'b0, '0, 1'b1);
            check("drain_lkahd", rdempty_lkahd, exp_lk);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        check("drain_count", n_pop, 8);
        check("drain_empty", rdempty, 1);
        check("drain_dout_hold", dout, 4'h7);

        // Read while empty
        drive(1'b0, '0, 1'b1);
        check("unf_lkahd", rdempty_lkahd, 1);
        tick();
        pos = 0; hits = 0;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, '0, 1'b0);
            check("unf_dout", dout, 4'h7);
            check("unf_empty", rdempty, 1);
            if (underflow) begin
                hits++;
                if (pos == 0) pos = k;
            end
            tick();
        end
        check("unf_pulses", hits, 1);
        check("unf_position", pos, 2);
        check("unf_wrusedw", wrusedw, 0);

        // Steady-state simultaneous read and write at 4 entries
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, DWD'(9 + k), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        repeat (5) tick();
        check("steady_pre_usedw", wrusedw, 4);
        check("steady_pre_dout", dout, 4'h9);
        for (int j = 0; j < 7; j++) begin
            drive(j < 6, DWD'(13 + j), j > 0);
            check("steady_usedw", wrusedw, 4);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        check("steady_post_usedw", wrusedw, 4);
        check("steady_pops", n_pop, 14);

        // Reset mid-burst with 5 entries held
        drive(1'b1, 4'h3, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        repeat (4) tick();
        check("mid_usedw5", wrusedw, 5);
        check("mid_dout", dout, 4'hF);
        drive(1'b1, 4'h6, 1'b0);
        tick();
        drive(1'b1, 4'h8, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_empty", rdempty, 1);
        check("mid_rst_full", wrfull, 0);
        check("mid_rst_usedw", wrusedw, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_unf", underflow, 0);
        wrreq = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            check("rst_flush", {rdempty, wrusedw}, {1'b1, 3'd0});
            tick();
        end

        // Clean restart after reset
        drive(1'b1, 4'h5, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        n = 0;
        while (rdempty && n < 10) begin
            tick();
            n++;
        end
        check("restart_latency", n, 3);
        drive(1'b0, '0, 1'b1);
        check("restart_lkahd", rdempty_lkahd, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        check("restart_empty", rdempty, 1);
        check("restart_pops", n_pop, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
